// File: rtl/sseg_scan_ctrl.sv
// ============================================================================
// sseg_scan_ctrl : 4-digit multiplexed seven-segment scanner with guard
// blanking, PWM brightness, per-digit blink and a frame-synchronous update buffer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sseg_scan_ctrl #(
  parameter int CLK_DIV      = 50000,
  parameter int DEAD         = 4,
  parameter int BLINK_FRAMES = 64
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic [3:0][7:0] i_digits_n,
  input  logic            i_wr_valid,
  output logic            o_wr_ready,
  input  logic [3:0]      i_digit_en,
  input  logic [3:0]      i_bright,
  input  logic [3:0]      i_blink_en,
  output logic [3:0]      o_ldsel,
  output logic [7:0]      o_sseg_n,
  output logic            o_frame_tick
);

  localparam int            PW       = $clog2(CLK_DIV);
  localparam int            FW       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0]   presc_q, presc_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0]      pwm_q, pwm_d;
  logic [FW-1:0]   frm_q, frm_d;
  logic            blink_q, blink_d;
  logic [3:0][7:0] pend_q, pend_d;
  logic [3:0][7:0] act_q, act_d;
  logic            full_q, full_d;
  logic            ready_q, ready_d;
  logic [3:0]      ldsel_q, ldsel_d;
  logic [7:0]      sseg_q, sseg_d;
  logic            tick_q, tick_d;

  logic slot_end;
  logic frame_end;
  logic guard_ok;
  logic lit;

  assign slot_end  = (presc_q == PRE_LAST);
  assign frame_end = slot_end && (idx_q == 2'd3);

  generate
    if (DEAD == 0) begin : g_no_guard
      assign guard_ok = 1'b1;
    end else begin : g_guard
      localparam logic [PW-1:0] DEAD_V = PW'(DEAD);
      assign guard_ok = (presc_q >= DEAD_V);
    end
  endgenerate

  assign lit = guard_ok && i_digit_en[idx_q] && (pwm_q <= i_bright) &&
               (!i_blink_en[idx_q] || !blink_q);

  always_comb begin
    presc_d = slot_end ? '0 : presc_q + 1'b1;
    idx_d   = slot_end ? idx_q + 2'd1 : idx_q;
    pwm_d   = pwm_q + 4'd1;
    frm_d   = frm_q;
    blink_d = blink_q;
    pend_d  = pend_q;
    act_d   = act_q;
    full_d  = full_q;

    if (frame_end) begin
      if (frm_q == FRM_LAST) begin
        frm_d   = '0;
        blink_d = ~blink_q;
      end else begin
        frm_d = frm_q + 1'b1;
      end
    end

    // Promotion looks at the registered full flag, so a write landing on the
    // boundary cycle waits for the next boundary.
    if (frame_end && full_q) begin
      act_d  = pend_q;
      full_d = 1'b0;
    end
    if (i_wr_valid && !full_q) begin
      pend_d = i_digits_n;
      full_d = 1'b1;
    end

    ready_d = ~full_d;
    ldsel_d = lit ? (4'b0001 << idx_q) : 4'b0000;
    sseg_d  = lit ? act_q[idx_q] : 8'hFF;
    tick_d  = frame_end;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      presc_q <= '0;
      idx_q   <= '0;
      pwm_q   <= '0;
      frm_q   <= '0;
      blink_q <= 1'b0;
      pend_q  <= {4{8'hFF}};
      act_q   <= {4{8'hFF}};
      full_q  <= 1'b0;
      ready_q <= 1'b1;
      ldsel_q <= 4'b0000;
      sseg_q  <= 8'hFF;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      pwm_q   <= pwm_d;
      frm_q   <= frm_d;
      blink_q <= blink_d;
      pend_q  <= pend_d;
      act_q   <= act_d;
      full_q  <= full_d;
      ready_q <= ready_d;
      ldsel_q <= ldsel_d;
      sseg_q  <= sseg_d;
      tick_q  <= tick_d;
    end
  end

  assign o_wr_ready   = ready_q;
  assign o_ldsel      = ldsel_q;
  assign o_sseg_n     = sseg_q;
  assign o_frame_tick = tick_q;

endmodule

`default_nettype wire

// File: tb/tb_sseg_scan_ctrl.sv
// ============================================================================
// tb_sseg_scan_ctrl : vector table, directed sequences and random stimulus
// compared against an arithmetic model of the scanner.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sseg_scan_ctrl;

  localparam int CD  = 16;
  localparam int DD  = 2;
  localparam int BF  = 2;
  localparam int FRM = CD * 4;

  logic            i_clk = 1'b0;
  logic            i_reset_n = 1'b0;
  logic [3:0][7:0] i_digits_n = '1;
  logic            i_wr_valid = 1'b0;
  logic            o_wr_ready;
  logic [3:0]      i_digit_en = 4'hF;
  logic [3:0]      i_bright = 4'hF;
  logic [3:0]      i_blink_en = 4'h0;
  logic [3:0]      o_ldsel;
  logic [7:0]      o_sseg_n;
  logic            o_frame_tick;

  sseg_scan_ctrl #(.CLK_DIV(CD), .DEAD(DD), .BLINK_FRAMES(BF)) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_digits_n   (i_digits_n),
    .i_wr_valid   (i_wr_valid),
    .o_wr_ready   (o_wr_ready),
    .i_digit_en   (i_digit_en),
    .i_bright     (i_bright),
    .i_blink_en   (i_blink_en),
    .o_ldsel      (o_ldsel),
    .o_sseg_n     (o_sseg_n),
    .o_frame_tick (o_frame_tick)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  int n_edges = 0;

  // Reference model: scan position is pure arithmetic on edges since reset.
  logic [7:0] m_act [4];
  logic [7:0] m_pend[4];
  bit         m_full;

  typedef struct {
    int         edge_no;
    logic [3:0] ld;
    logic [7:0] ss;
    logic       tick;
  } vec_t;
  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d got=%h expected=%h", name, n_edges, got, exp);
    end
  endtask

  task automatic model_reset();
    n_edges = 0;
    m_full  = 0;
    for (int k = 0; k < 4; k++) begin
      m_act[k]  = 8'hFF;
      m_pend[k] = 8'hFF;
    end
  endtask

  task automatic step(input logic v, input logic [31:0] data, input logic [3:0] en,
                      input logic [3:0] br, input logic [3:0] bl);
    int         s, ph, idx, blink;
    bit         lit, rdy_pre;
    logic [3:0] exp_ld;
    logic [7:0] exp_ss;
    logic       exp_tick;
    @(negedge i_clk);
    i_wr_valid = v;
    i_digits_n = data;
    i_digit_en = en;
    i_bright   = br;
    i_blink_en = bl;
    s     = n_edges;
    ph    = s % CD;
    idx   = (s / CD) % 4;
    blink = ((s / FRM) / BF) % 2;
    lit   = (ph >= DD) && en[idx] && ((s % 16) <= int'(br)) && (!bl[idx] || blink == 0);
    exp_ld   = lit ? 4'(1 << idx) : 4'b0000;
    exp_ss   = lit ? m_act[idx] : 8'hFF;
    exp_tick = ((s % FRM) == FRM - 1);
    rdy_pre  = !m_full;
    if (exp_tick && m_full) begin
      m_act  = m_pend;
      m_full = 0;
    end
    if (v && rdy_pre) begin
      for (int k = 0; k < 4; k++) m_pend[k] = data[8*k +: 8];
      m_full = 1;
    end
    @(posedge i_clk);
    #1;
    n_edges++;
    check("ldsel", 32'(o_ldsel), 32'(exp_ld));
    check("sseg_n", 32'(o_sseg_n), 32'(exp_ss));
    check("frame_tick", 32'(o_frame_tick), 32'(exp_tick));
    check("wr_ready", 32'(o_wr_ready), 32'(!m_full));
    check("onehot0", 32'($onehot0(o_ldsel)), 32'd1);
  endtask

  task automatic idle_until(input int e, input logic [3:0] en, input logic [3:0] br,
                            input logic [3:0] bl);
    while (n_edges < e) step(1'b0, 32'hFFFF_FFFF, en, br, bl);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ldsel"}, 32'(o_ldsel), 32'h0);
    check({tag, "_sseg_n"}, 32'(o_sseg_n), 32'hFF);
    check({tag, "_tick"}, 32'(o_frame_tick), 32'h0);
    check({tag, "_ready"}, 32'(o_wr_ready), 32'h1);
  endtask

  initial begin
    int lit_cnt;
    bit d0_seen;

    tbl[0]  = '{1,   4'b0000, 8'hFF, 1'b0};
    tbl[1]  = '{3,   4'b0001, 8'hFF, 1'b0};
    tbl[2]  = '{16,  4'b0001, 8'hFF, 1'b0};
    tbl[3]  = '{17,  4'b0000, 8'hFF, 1'b0};
    tbl[4]  = '{18,  4'b0000, 8'hFF, 1'b0};
    tbl[5]  = '{19,  4'b0010, 8'hFF, 1'b0};
    tbl[6]  = '{35,  4'b0100, 8'hFF, 1'b0};
    tbl[7]  = '{51,  4'b1000, 8'hFF, 1'b0};
    tbl[8]  = '{64,  4'b1000, 8'hFF, 1'b1};
    tbl[9]  = '{65,  4'b0000, 8'hFF, 1'b0};
    tbl[10] = '{67,  4'b0001, 8'hFF, 1'b0};
    tbl[11] = '{128, 4'b1000, 8'hFF, 1'b1};

    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    check_reset_outputs("por");
    @(posedge i_clk);
    #2 i_reset_n = 1'b1;

    // Scan sequence after reset, no writes
    for (int i = 0; i < 12; i++) begin
      idle_until(tbl[i].edge_no, 4'hF, 4'hF, 4'h0);
      check("tbl_ldsel", 32'(o_ldsel), 32'(tbl[i].ld));
      check("tbl_sseg_n", 32'(o_sseg_n), 32'(tbl[i].ss));
      check("tbl_tick", 32'(o_frame_tick), 32'(tbl[i].tick));
    end

    // Mid-frame write, ignored second write, promotion at boundary
    idle_until(150, 4'hF, 4'hF, 4'h0);
    step(1'b1, 32'hB0A4_F9C0, 4'hF, 4'hF, 4'h0);
    check("wr_ready_drop", 32'(o_wr_ready), 32'h0);
    step(1'b1, 32'h1234_5678, 4'hF, 4'hF, 4'h0);
    idle_until(191, 4'hF, 4'hF, 4'h0);
    check("wr_ready_hold", 32'(o_wr_ready), 32'h0);
    idle_until(192, 4'hF, 4'hF, 4'h0);
    check("wr_ready_return", 32'(o_wr_ready), 32'h1);
    idle_until(195, 4'hF, 4'hF, 4'h0);
    check("digit0_new", 32'(o_sseg_n), 32'hC0);
    idle_until(243, 4'hF, 4'hF, 4'h0);
    check("digit3_new", 32'(o_sseg_n), 32'hB0);

    // Write on the boundary cycle itself lands one frame later
    idle_until(255, 4'hF, 4'hF, 4'h0);
    step(1'b1, 32'h9992_82F8, 4'hF, 4'hF, 4'h0);
    idle_until(259, 4'hF, 4'hF, 4'h0);
    check("boundary_wr_old", 32'(o_sseg_n), 32'hC0);
    idle_until(323, 4'hF, 4'hF, 4'h0);
    check("boundary_wr_new", 32'(o_sseg_n), 32'hF8);

    // Reduced brightness over one full frame
    lit_cnt = 0;
    for (int i = 0; i < FRM; i++) begin
      step(1'b0, 32'hFFFF_FFFF, 4'hF, 4'd3, 4'h0);
      if (o_ldsel != 4'b0000) lit_cnt++;
    end
    check("bright3_lit_count", 32'(lit_cnt), 32'd8);

    // Blink on digit 2 with digit 0 disabled
    d0_seen = 0;
    for (int i = 0; i < 8 * FRM; i++) begin
      step(1'b0, 32'hFFFF_FFFF, 4'b1110, 4'hF, 4'b0100);
      if (o_ldsel[0]) d0_seen = 1;
    end
    check("digit0_never", 32'(d0_seen), 32'h0);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 19) == 0), $urandom, 4'($urandom), 4'($urandom), 4'($urandom));
    end

    // Reset mid-slot with a write pending
    idle_until(((n_edges / FRM) + 1) * FRM + 5, 4'hF, 4'hF, 4'h0);
    step(1'b1, 32'h0102_0304, 4'hF, 4'hF, 4'h0);
    idle_until(n_edges + 3, 4'hF, 4'hF, 4'h0);
    check("pre_reset_lit", 32'(o_ldsel != 4'b0000), 32'h1);
    @(negedge i_clk);
    #2 i_reset_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(posedge i_clk);
    #1;
    check_reset_outputs("held_rst");
    model_reset();
    #1 i_reset_n = 1'b1;
    for (int i = 0; i < 3 * FRM; i++) step(1'b0, 32'hFFFF_FFFF, 4'hF, 4'hF, 4'h0);
    check("post_rst_ready", 32'(o_wr_ready), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
